// File: rtl/div_pkg.sv
// Shared definitions for the 4-bit signed restoring divider.
// FSM state encoding, operand width and iteration count.
package div_pkg;

    localparam int WIDTH = 4;
    localparam int ITERS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude in WIDTH+1 bits so that |-8| = 8 is representable
    function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] e;
        e = {v[WIDTH-1], v};
        return v[WIDTH-1] ? (~e + 1'b1) : e;
    endfunction

endpackage

// File: rtl/div_u4_step.sv
// One restoring-division step on 5-bit unsigned magnitudes.
// Shift in the next dividend bit, trial-subtract, keep if non-negative.
module div_u4_step
    import div_pkg::*;
(
    input  logic [WIDTH:0] rem_in,
    input  logic           dbit,
    input  logic [WIDTH:0] dvsr,
    output logic [WIDTH:0] rem_out,
    output logic           qbit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in[WIDTH-1:0], dbit};
        diff    = {1'b0, shifted} - {1'b0, dvsr};
        qbit    = ~diff[WIDTH+1];
        rem_out = qbit ? diff[WIDTH:0] : shifted;
    end

endmodule

// File: rtl/div_s4_bits.sv
// 4-bit signed truncating divider: sign/magnitude split, four restoring
// steps, then sign fix-up. Fixed 6-edge latency from accept to done.
module div_s4_bits
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    state_t           state, state_n;
    logic [1:0]       cnt;
    logic [WIDTH:0]   mag_x, mag_y;
    logic             neg_r, neg_q;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] qmag;

    logic [WIDTH:0]   step_rem;
    logic             step_q;

    logic [WIDTH-1:0] quot_fix, rem_fix;
    logic             dbz_fix, ovf_fix;

    div_u4_step u_step (
        .rem_in  (prem),
        .dbit    (mag_x[cnt]),
        .dvsr    (mag_y),
        .rem_out (step_rem),
        .qbit    (step_q)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = CALC;
            CALC:    if (cnt == 2'd0) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Sign application and flag derivation for the FIX cycle
    always_comb begin
        dbz_fix  = (mag_y == '0);
        ovf_fix  = neg_r & ~neg_q & (mag_x == 5'd8) & (mag_y == 5'd1);
        quot_fix = neg_q ? (~qmag + 1'b1) : qmag;
        rem_fix  = neg_r ? (~prem[WIDTH-1:0] + 1'b1) : prem[WIDTH-1:0];
        if (dbz_fix) quot_fix = '1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mag_x <= '0;
            mag_y <= '0;
            neg_r <= 1'b0;
            neg_q <= 1'b0;
            prem  <= '0;
            qmag  <= '0;
            quot  <= '0;
            rem   <= '0;
            done  <= 1'b0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    mag_x <= mag(x);
                    mag_y <= mag(y);
                    neg_r <= x[WIDTH-1];
                    neg_q <= x[WIDTH-1] ^ y[WIDTH-1];
                    prem  <= '0;
                    qmag  <= '0;
                    cnt   <= 2'(ITERS - 1);
                end
                CALC: begin
                    prem <= step_rem;
                    qmag <= {qmag[WIDTH-2:0], step_q};
                    cnt  <= cnt - 1'b1;
                end
                FIX: begin
                    quot <= quot_fix;
                    rem  <= rem_fix;
                    dbz  <= dbz_fix;
                    ovf  <= ovf_fix;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_s4_bits.sv
// Self-checking bench for div_s4_bits: directed table, random ops
// against an arithmetic model, and busy/reset corner sequences.
module tb_div_s4_bits;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] x, y;
    logic [3:0] quot, rem;
    logic       busy, done, dbz, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    div_s4_bits dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .quot  (quot),
        .rem   (rem),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        logic       o;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer truncating division
    task automatic model(input logic [3:0] xi, input logic [3:0] yi,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic z, output logic o);
        int sx, sy, iq, ir;
        sx = $signed(xi);
        sy = $signed(yi);
        z  = (sy == 0);
        o  = (sx == -8 && sy == -1);
        if (z) begin
            q = 4'hF;
            r = xi;
        end else begin
            iq = sx / sy;
            ir = sx % sy;
            q  = 4'(iq);
            r  = 4'(ir);
        end
    endtask

    // Issue one op, check 6-edge latency and the registered results
    task automatic run_op(input string tag, input logic [3:0] xi,
                          input logic [3:0] yi, input logic [3:0] eq,
                          input logic [3:0] er, input logic ez,
                          input logic eo);
        int k;
        @(negedge clk);
        x = xi;
        y = yi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy"}, int'(busy), 1);
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = i;
                break;
            end
        end
        chk({tag, " latency"}, k, 5);
        chk({tag, " quot"}, int'(quot), int'(eq));
        chk({tag, " rem"}, int'(rem), int'(er));
        chk({tag, " dbz"}, int'(dbz), int'(ez));
        chk({tag, " ovf"}, int'(ovf), int'(eo));
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, int'(done), 0);
    endtask

    vec_t tbl[6];

    initial begin
        logic [3:0] mq, mr;
        logic       mz, mo;
        logic [3:0] rx, ry;
        int         ndone;

        tbl[0] = '{4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0};
        tbl[1] = '{4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0};
        tbl[2] = '{4'h7, 4'hD, 4'hE, 4'h1, 1'b0, 1'b0};
        tbl[3] = '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1};
        tbl[4] = '{4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0};
        tbl[5] = '{4'h8, 4'h3, 4'hE, 4'hE, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset quot", int'(quot), 0);
        chk("reset rem", int'(rem), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset flags", int'({dbz, ovf}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), tbl[i].x, tbl[i].y,
                   tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].o);

        for (int i = 0; i < 40; i++) begin
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            model(rx, ry, mq, mr, mz, mo);
            run_op($sformatf("rnd%0d %0h/%0h", i, rx, ry),
                   rx, ry, mq, mr, mz, mo);
        end

        // Start while busy must be dropped
        @(negedge clk);
        x = 4'h6;
        y = 4'h4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        x = 4'h9;
        y = 4'h3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("busy-start dones", ndone, 1);
        chk("busy-start quot", int'(quot), 1);
        chk("busy-start rem", int'(rem), 2);

        // Reset during CALC clears outputs immediately
        @(negedge clk);
        x = 4'h7;
        y = 4'h2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst quot", int'(quot), 0);
        chk("midrst rem", int'(rem), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("post-rst no done", ndone, 0);
        run_op("after rst", 4'hE, 4'h3, 4'h0, 4'hE, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
